// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - round-robin N-channel stream mux with registered output stage
// Packet locking is built only when RR_STREAM_MUX_PKT_LOCK_EN is defined.
module rr_stream_mux #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_CH    = 4,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH-1:0]           in_last,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic                        out_last,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam logic [CH_W:0]   NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [CH_W-1:0]      out_ch_q, out_ch_d;
    logic                 out_valid_q, out_valid_d;

    logic [NUM_CH-1:0]    rot;
    logic [CH_W:0]        rr_sum;
    logic                 rr_found;
    logic [CH_W-1:0]      rr_gnt, gnt;
    logic [BUS_WIDTH-1:0] sel_data;
    logic                 sel_valid, sel_last, load, accept;

    // Rotate valids so bit 0 is the channel at ptr; the first set bit wins.
    always_comb begin
        rot      = NUM_CH'({in_valid, in_valid} >> ptr_q);
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rr_found && rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, ptr_q} + (CH_W+1)'(k);
            end
        end
        if (rr_sum >= NUM_CH_W) begin
            rr_sum = rr_sum - NUM_CH_W;
        end
        rr_gnt = rr_sum[CH_W-1:0];
    end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;

    assign gnt = (state_q == LOCKED) ? lock_ch_q : rr_gnt;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            IDLE: begin
                if (accept && !sel_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = gnt;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    assign gnt = rr_gnt;
`endif

    // When nothing is valid the grant falls on an invalid channel, so sel_valid stays low.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt == CH_W'(c)) begin
                sel_data  = in_data[c*BUS_WIDTH +: BUS_WIDTH];
                sel_valid = in_valid[c];
                sel_last  = in_last[c];
            end
        end
    end

    assign load   = !out_valid_q || out_ready;
    assign accept = rst_n && load && sel_valid;

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c] = accept && (gnt == CH_W'(c));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_ch_d    = gnt;
            ptr_d       = (gnt == LAST_CH) ? '0 : gnt + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - self-checking bench for rr_stream_mux (4-channel and 3-channel instances)
module tb_rr_stream_mux;
    localparam int BW = 8;
    localparam int N  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*BW-1:0] in_data;
    logic [N-1:0]    in_valid, in_last, in_ready;
    logic [BW-1:0]   out_data;
    logic            out_last, out_valid, out_ready;
    logic [1:0]      out_ch;

    logic [3*BW-1:0] d3_in_data;
    logic [2:0]      d3_in_valid, d3_in_last, d3_in_ready;
    logic [BW-1:0]   d3_out_data;
    logic            d3_out_last, d3_out_valid, d3_out_ready;
    logic [1:0]      d3_out_ch;

    int n_tests = 0;
    int n_fail  = 0;

    rr_stream_mux #(.BUS_WIDTH(BW), .NUM_CH(N)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_stream_mux #(.BUS_WIDTH(BW), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_last(d3_in_last), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_last(d3_out_last), .out_ch(d3_out_ch),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready)
    );

    task automatic idle_inputs();
        in_data      = '0;
        in_valid     = '0;
        in_last      = '0;
        out_ready    = 1'b1;
        d3_in_data   = '0;
        d3_in_valid  = '0;
        d3_in_last   = '0;
        d3_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '1;
        in_last  = '1;
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) in_data[c*BW +: BW] = 8'(8'h40 + c);
        @(negedge clk);
        #1;
        n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 8'h00 || out_last !== 1'b0 || out_ch !== 2'd0) begin
            n_fail++; $display("FAIL reset_out_regs: got data=%h last=%b ch=%0d expected 00/0/0", out_data, out_last, out_ch);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % N) || out_data !== 8'(8'h40 + (i % N))) begin
                n_fail++;
                $display("FAIL reset_order[%0d]: got v=%b ch=%0d data=%h expected v=1 ch=%0d data=%h",
                         i, out_valid, out_ch, out_data, i % N, 8'(8'h40 + (i % N)));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        in_last   = 4'b0000;
        in_data[1*BW +: BW] = 8'h31;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin
            n_fail++; $display("FAIL midrst_held: got v=%b data=%h expected 1/31", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_async: got v=%b rdy=%b expected 0/0000", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0101;
        in_last   = 4'b1111;
        in_data[0*BW +: BW] = 8'h50;
        in_data[2*BW +: BW] = 8'h52;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h50) begin
            n_fail++; $display("FAIL midrst_after: got v=%b ch=%0d data=%h expected 1/0/50", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        in_last   = 4'b1111;
        in_data[2*BW +: BW] = 8'hA5;
        @(negedge clk);
        in_valid = 4'b0101;
        in_data[0*BW +: BW] = 8'h77;
        in_data[2*BW +: BW] = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2 || in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b data=%h ch=%0d rdy=%b expected 1/a5/2/0000",
                         i, out_valid, out_data, out_ch, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL bp_release: got v=%b data=%h expected 1/a5", out_valid, out_data);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_no_dup[%0d]: got v=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_pkt_lock();
        int ech[$];
        int edat[$];
        int elast[$];
        int idx, nb;
        logic acc1;
        logic [7:0] pkt [3];
        pkt[0] = 8'h11; pkt[1] = 8'h12; pkt[2] = 8'h13;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        ech   = '{0, 1, 1, 1, 3};
        edat  = '{'h0A, 'h11, 'h12, 'h13, 'h3C};
        elast = '{1, 0, 0, 1, 0};
`else
        ech   = '{0, 1, 3, 0, 1, 3, 0, 1};
        edat  = '{'h0A, 'h11, 'h3C, 'h0A, 'h12, 'h3C, 'h0A, 'h13};
        elast = '{1, 0, 0, 0, 0, 0, 0, 1};
`endif
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        in_data[0*BW +: BW] = 8'h0A;
        idx = 0;
        nb  = 0;
        for (int cyc = 0; cyc < 16 && nb < ech.size(); cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_ch !== 2'(ech[nb]) || out_data !== 8'(edat[nb]) || out_last !== 1'(elast[nb])) begin
                    n_fail++;
                    $display("FAIL pkt_beat[%0d]: got ch=%0d data=%h last=%b expected ch=%0d data=%h last=%0d",
                             nb, out_ch, out_data, out_last, ech[nb], edat[nb], elast[nb]);
                end
                nb++;
            end
            in_valid = {1'b1, 1'b0, (idx < 3), 1'b1};
            in_last  = {1'b0, 1'b0, (idx == 2), 1'b0};
            in_data[3*BW +: BW] = 8'h3C;
            in_data[1*BW +: BW] = (idx < 3) ? pkt[idx] : 8'h00;
            #1;
            acc1 = in_ready[1];
            @(posedge clk);
            if (acc1) idx++;
        end
        n_tests++; if (nb != ech.size()) begin
            n_fail++; $display("FAIL pkt_count: got %0d beats expected %0d", nb, ech.size());
        end
    endtask

    task automatic test_lock_gap();
        logic [3:0] sch_v [7];
        logic [3:0] erdy  [7];
        int ech[$];
        int edat[$];
        int nb;
        sch_v = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        erdy = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
        ech  = '{1, 1, 0};
        edat = '{'h21, 'h22, 'h0F};
`else
        erdy = '{4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
        ech  = '{1, 0, 0};
        edat = '{'h21, 'h0F, 'h0F};
`endif
        do_reset();
        out_ready = 1'b1;
        nb = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid === 1'b1 && nb < 3) begin
                n_tests++;
                if (out_ch !== 2'(ech[nb]) || out_data !== 8'(edat[nb])) begin
                    n_fail++;
                    $display("FAIL gap_beat[%0d]: got ch=%0d data=%h expected ch=%0d data=%h",
                             nb, out_ch, out_data, ech[nb], edat[nb]);
                end
                nb++;
            end
            if (cyc < 7) begin
                in_valid = sch_v[cyc];
                in_last  = (cyc == 0) ? 4'b0001 : 4'b0011;
                in_data[0*BW +: BW] = 8'h0F;
                in_data[1*BW +: BW] = (cyc == 0) ? 8'h21 : 8'h22;
                #1;
                n_tests++;
                if (in_ready !== erdy[cyc]) begin
                    n_fail++;
                    $display("FAIL gap_ready[%0d]: got %b expected %b", cyc, in_ready, erdy[cyc]);
                end
            end
        end
        n_tests++; if (nb != 3) begin
            n_fail++; $display("FAIL gap_count: got %0d beats expected 3", nb);
        end
    endtask

    task automatic test_wrap3();
        do_reset();
        d3_out_ready = 1'b1;
        d3_in_valid  = 3'b111;
        d3_in_last   = 3'b111;
        for (int c = 0; c < 3; c++) d3_in_data[c*BW +: BW] = 8'(8'h60 + c);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_tests++;
            if (d3_out_valid !== 1'b1 || d3_out_ch !== 2'(i % 3) || d3_out_data !== 8'(8'h60 + (i % 3))) begin
                n_fail++;
                $display("FAIL wrap3[%0d]: got v=%b ch=%0d data=%h expected 1/%0d/%h",
                         i, d3_out_valid, d3_out_ch, d3_out_data, i % 3, 8'(8'h60 + (i % 3)));
            end
        end
        d3_in_valid = 3'b000;
    endtask

    task automatic test_random();
        logic          m_valid, m_last;
        logic [BW-1:0] m_data;
        int            m_ch, m_ptr, m_lock, g, idx;
        logic [N-1:0]  exp_rdy;
        do_reset();
        m_valid = 1'b0; m_last = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_lock = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            n_tests++;
            if (out_valid !== m_valid) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, out_valid, m_valid);
            end
            if (m_valid) begin
                n_tests++;
                if (out_data !== m_data || out_last !== m_last || int'(out_ch) != m_ch) begin
                    n_fail++;
                    $display("FAIL rnd_beat@%0d: got data=%h last=%b ch=%0d expected data=%h last=%b ch=%0d",
                             cyc, out_data, out_last, out_ch, m_data, m_last, m_ch);
                end
            end
            in_valid  = 4'($urandom);
            for (int c = 0; c < N; c++) in_last[c] = ($urandom_range(0, 2) == 0);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (m_lock >= 0) begin
                if (in_valid[m_lock]) g = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
            end
            exp_rdy = '0;
            if ((!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            n_tests++;
            if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            @(posedge clk);
            if (exp_rdy != '0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*BW +: BW];
                m_last  = in_last[g];
                m_ch    = g;
                m_ptr   = (g + 1) % N;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
                if (m_lock < 0 && !in_last[g]) m_lock = g;
                else if (m_lock >= 0 && in_last[g]) m_lock = -1;
`endif
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_packet();
        test_backpressure();
        test_pkt_lock();
        test_lock_gap();
        test_wrap3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel streaming multiplexer with round-robin arbitration, valid/ready handshakes on every port, a registered output stage and optional packet locking. It merges several producer streams onto one consumer bus without software-driven select lines, and tags each beat with its source channel. It sits between multiple bus masters and a shared datapath.

## Interface
- BUS_WIDTH, 8, data width per channel
- NUM_CH, 4, number of input channels (2..16, any integer, not limited to powers of two)
- CH_W, localparam = $clog2(NUM_CH), channel-index width

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NUM_CH*BUS_WIDTH  channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH]
- in_valid  input  NUM_CH  per-channel beat valid
- in_last  input  NUM_CH  per-channel end-of-packet marker
- in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle
- out_data  output  BUS_WIDTH  registered beat data
- out_last  output  1  registered end-of-packet marker
- out_ch  output  CH_W  registered source channel of current beat
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer accept

## Operation
- Transfers: input beat on i when in_valid[i] && in_ready[i]; output beat when out_valid && out_ready.
- load = !out_valid || out_ready. The output register loads only when load is high.
- Grant (combinational):
  - IDLE: the first channel with in_valid set, searching upward from ptr and wrapping NUM_CH-1 -> 0.
  - LOCKED: lock_ch.
- in_ready[g] = load && in_valid-qualified grant g exists; all other in_ready bits are 0.
- On an accepted input beat from g:
  - out_data, out_last and out_ch load from channel g; out_valid <= 1.
  - ptr <= (g == NUM_CH-1) ? 0 : g+1.
- If out_ready is high and no input beat is accepted, out_valid <= 0. Data holds its last value.
- Output data, last and ch stay stable while out_valid && !out_ready.
- States (packet lock only):
  - IDLE -> LOCKED when a beat with in_last=0 is accepted; lock_ch <= g.
  - LOCKED -> IDLE when a beat from lock_ch with in_last=1 is accepted.
- Boundaries:
  - Locked channel drops in_valid mid-packet: the lock holds, other channels stall, and no beat is stolen.
  - A single-beat packet (in_last=1 on the first beat) never enters LOCKED.
  - No channel valid: no in_ready asserted, and ptr and state are unchanged.
  - ptr wraps correctly for non-power-of-two NUM_CH and never holds a value >= NUM_CH.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, ptr=0, state IDLE, lock_ch=0. While rst_n is low, in_ready is all 0.
- Reset is asynchronous assert and synchronous-to-clk deassert by the system. Reset mid-packet discards the held beat and clears the lock.
- Latency: input acceptance at edge N produces out_valid at edge N (visible in cycle N+1). That is one cycle.
- Throughput: one beat per cycle under continuous out_ready, including back-to-back beats from different channels.
- in_ready depends combinationally on out_ready, out_valid, in_valid, ptr and state. out_* has no combinational path from inputs.
- Priority ordering after reset: ch0 highest.

## Configuration
- RR_STREAM_MUX_PKT_LOCK_EN defined: packet locking is active as described, and LOCKED state and lock_ch are built.
- Not defined:
  - Re-arbitration happens on every beat.
  - The FSM and lock_ch are removed.
  - in_last passes through to out_last unchanged, with no effect on grant.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1.
  - Required: in_ready=0 and out_valid=0.
  - After release with out_ready=1 (NUM_CH=4), beats come out with out_ch 0,1,2,3,0.
- Backpressure: ch2 sends 0xA5 and out_ready=0 for 5 cycles.
  - Required: out_data=0xA5 and out_ch=2 stay stable, with in_ready=0 throughout.
  - Releasing out_ready produces one transfer of 0xA5 with no duplicate.
- Packet lock (macro defined): ch1 sends a 3-beat packet 0x11, 0x12, 0x13(last) while ch0 and ch3 are valid.
  - Required: out_ch=1 for all three beats, consecutively.
  - The next grant goes to ch3.
- Lock with gap (macro defined): ch1 drops in_valid for 2 cycles mid-packet while ch0 is valid.
  - Required: no ch0 beat is emitted until ch1 sends its last beat.
- Non-power-of-two wrap: NUM_CH=3, all valid, out_ready=1 for 7 beats.
  - Required: out_ch sequence 0,1,2,0,1,2,0.
- Macro undefined, same stimulus as the packet-lock test.
  - Required: out_ch alternates 1,3,0,1,… with out_last=1 only on the 0x13 beat.
